vsdma_wr_arbiter: RTL and testbench
===================================

// Module: vsdma_wr_arbiter
// PURPOSE
//  N-channel write-request arbiter for the vsdma request/data interface, all in ui_clk domain.
//  Merges NCH independent vsdma_control write ports onto one vsdma_to_axi write port.
//  Supports round-robin or fixed-priority arbitration, a grant held for a whole burst, and a handshake timeout.
//  Successor to the single-channel write path; lets several video streams share one DDR AXI master.
// PARAMETERS
//  NCH          4      number of channels, 2..8
//  ADDR_W       28     vsdma address width
//  DATA_W       256    vsdma data width
//  SIZE_W       16     burst size field width
//  RR_MODE      1      1 = round-robin, 0 = fixed priority (lowest index wins)
//  TIMEOUT      1023   max cycles in REQ waiting for m_wbusy; 0 = never time out
// PORTS
//  ui_clk       in   1             clock
//  ui_rst       in   1             async active-high reset
//  ch_waddr     in   NCH*ADDR_W    per-channel burst address; ch i = bits [i*ADDR_W +: ADDR_W]
//  ch_wareq     in   NCH           per-channel request level
//  ch_wsize     in   NCH*SIZE_W    per-channel burst size in beats
//  ch_wdata     in   NCH*DATA_W    per-channel write data
//  ch_wbusy     out  NCH           1 = this channel owns the port
//  ch_wrd       out  NCH           per-channel beat-consumed strobe
//  m_waddr      out  ADDR_W        address to vsdma_to_axi (registered at grant)
//  m_wareq      out  1             request to vsdma_to_axi
//  m_wsize      out  SIZE_W        size to vsdma_to_axi (registered at grant)
//  m_wbusy      in   1             vsdma_to_axi burst in progress
//  m_wdata      out  DATA_W        muxed write data = ch_wdata of the granted channel
//  m_wrd        in   1             downstream consumed one beat
//  grant_id     out  $clog2(NCH)   index of the current or last granted channel
//  err_timeout  out  1             one-cycle pulse when a request times out
// BEHAVIOUR
//  Reset (async, ui_rst=1):
//   - All outputs are 0; state = IDLE; pending = 0.
//   - rr_ptr = NCH-1, so channel 0 has first priority.
//  Request capture:
//   - pending[i] is set on the rising edge of ch_wareq[i], i.e. ch_wareq[i]=1 and the registered previous value = 0.
//   - pending[i] is cleared on the cycle channel i is granted.
//   - A level held high does not re-request.
//   - A rising edge on the same cycle as a grant to i leaves pending[i] set; it is not lost.
//  FSM states: IDLE, REQ, BUSY, DONE.
//  IDLE:
//   - If pending != 0, select winner g.
//   - RR_MODE=1: g is the first set bit searching upward from rr_ptr+1, wrapping mod NCH.
//   - RR_MODE=0: g is the lowest set bit.
//   - Next edge: latch grant_id=g, m_waddr=ch_waddr[g], m_wsize=ch_wsize[g]; set ch_wbusy[g]=1 and m_wareq=1.
//   - rr_ptr=g; clear pending[g]; go to REQ.
//  REQ:
//   - m_wareq is held 1 until m_wbusy=1 is sampled.
//   - On that sample: m_wareq=0, go to BUSY.
//   - The timeout counter increments each REQ cycle.
//   - If the count reaches TIMEOUT with m_wbusy still 0: m_wareq=0, ch_wbusy=0, err_timeout pulses 1 cycle, go to IDLE.
//  BUSY:
//   - Stay until m_wbusy=0 is sampled, then go to DONE.
//  DONE:
//   - Lasts 1 cycle; ch_wbusy[g]=0; go to IDLE.
//   - Guarantees a 1-cycle gap between bursts.
//  Data path (combinational from the registered grant_id):
//   - m_wdata = ch_wdata[grant_id].
//   - ch_wrd[i] = m_wrd & (i==grant_id) & state in {REQ,BUSY}; otherwise 0.
//   - m_wrd outside REQ/BUSY is ignored.
//  Handshake:
//   - At most one ch_wbusy bit is high at any time.
//   - ch_wbusy[g] rises 1 cycle after selection and falls in DONE.
//   - Latency from a pending edge to m_wareq=1 is 2 cycles when idle.
//  Boundaries:
//   - Simultaneous edges on all channels: served in order g = rr_ptr+1, +2, ... with no starvation.
//   - ch_wareq deasserted while granted: the burst continues (request is edge-based).
//   - m_wbusy already 1 on entry to REQ: move to BUSY on the next cycle.
//   - Reset mid-burst: everything returns to reset values at once and all pending requests are discarded.
// TESTING (NCH=4, RR_MODE=1 unless noted)
//  1. Reset, then ch2 edge, addr 0x0010000, size 16, model acks busy 3 cycles later:
//     m_wareq rises 2 cycles after the edge; m_waddr=0x0010000, m_wsize=16.
//     ch_wbusy=4'b0100 until DONE; grant_id=2.
//  2. Edges on ch0..ch3 on the same cycle:
//     grants in order 0,1,2,3 with a DONE gap between each; no ch_wbusy overlap.
//  3. Same as 2 with RR_MODE=0, ch0 re-requesting after each of its bursts:
//     ch0 always wins and ch1..3 wait.
//  4. TIMEOUT=8, model never asserts m_wbusy:
//     err_timeout pulses after 8 REQ cycles; ch_wbusy returns to 0; state=IDLE; next pending channel is served.
//  5. Grant ch1, toggle m_wrd during BUSY:
//     only ch_wrd[1] follows m_wrd; m_wdata equals ch_wdata[1] each cycle.
//  6. Assert ui_rst mid-BUSY with pending 4'b1010:
//     all outputs 0 immediately; pending cleared; after release a new ch0 edge is granted first.

Source files
------------

// File: rtl/vsdma_wr_arbiter.sv
// vsdma_wr_arbiter: merges NCH vsdma write request/data ports onto one
// vsdma_to_axi write port. Grants are taken on request rising edges, held for
// a whole burst, arbitrated round-robin or fixed-priority, and abandoned with
// an error pulse if the downstream never acknowledges within TIMEOUT cycles.
module vsdma_wr_arbiter #(
  parameter int NCH     = 4,
  parameter int ADDR_W  = 28,
  parameter int DATA_W  = 256,
  parameter int SIZE_W  = 16,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 1023
) (
  input  logic                    ui_clk,
  input  logic                    ui_rst,
  input  logic [NCH*ADDR_W-1:0]   ch_waddr,
  input  logic [NCH-1:0]          ch_wareq,
  input  logic [NCH*SIZE_W-1:0]   ch_wsize,
  input  logic [NCH*DATA_W-1:0]   ch_wdata,
  output logic [NCH-1:0]          ch_wbusy,
  output logic [NCH-1:0]          ch_wrd,
  output logic [ADDR_W-1:0]       m_waddr,
  output logic                    m_wareq,
  output logic [SIZE_W-1:0]       m_wsize,
  input  logic                    m_wbusy,
  output logic [DATA_W-1:0]       m_wdata,
  input  logic                    m_wrd,
  output logic [$clog2(NCH)-1:0]  grant_id,
  output logic                    err_timeout
);

  localparam int ID_W = $clog2(NCH);
  // Counter only has to reach TIMEOUT-1; the REQ cycle that sees that value expires.
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_BUSY = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NCH-1:0]    wareq_prev_q;
  logic [NCH-1:0]    pending_q, pending_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [ADDR_W-1:0] m_waddr_q, m_waddr_d;
  logic [SIZE_W-1:0] m_wsize_q, m_wsize_d;
  logic [NCH-1:0]    ch_wbusy_q, ch_wbusy_d;
  logic              m_wareq_q, m_wareq_d;
  logic              err_q, err_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;

  logic [ADDR_W-1:0] waddr_arr [NCH];
  logic [SIZE_W-1:0] wsize_arr [NCH];
  logic [DATA_W-1:0] wdata_arr [NCH];
  logic [NCH-1:0]    rise;
  logic [NCH-1:0]    clr_mask;
  logic              win_valid;
  logic [ID_W-1:0]   win_id;
  logic              to_hit;
  logic              xfer_phase;

  // Split the flat per-channel buses into indexable arrays.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      waddr_arr[i] = ch_waddr[i*ADDR_W +: ADDR_W];
      wsize_arr[i] = ch_wsize[i*SIZE_W +: SIZE_W];
      wdata_arr[i] = ch_wdata[i*DATA_W +: DATA_W];
    end
  end

  // Pick the winner among pending channels (round-robin from rr_ptr+1, or lowest index).
  always_comb begin : winner_sel
    int idx;
    win_valid = |pending_q;
    win_id    = '0;
    idx       = 0;
    if (RR_MODE != 0) begin
      // Scan from the farthest candidate down so the closest one after rr_ptr wins.
      for (int k = NCH; k >= 1; k--) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (pending_q[idx]) win_id = ID_W'(idx);
      end
    end else begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (pending_q[i]) win_id = ID_W'(i);
      end
    end
  end

  assign rise   = ch_wareq & ~wareq_prev_q;
  assign to_hit = (TIMEOUT != 0) && (to_cnt_q == TO_W'(TIMEOUT - 1));

  // Next-state and registered-output logic of the grant FSM.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latch).
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    m_waddr_d  = m_waddr_q;
    m_wsize_d  = m_wsize_q;
    ch_wbusy_d = ch_wbusy_q;
    m_wareq_d  = m_wareq_q;
    err_d      = 1'b0;
    to_cnt_d   = to_cnt_q;
    clr_mask   = '0;

    case (state_q)
      S_IDLE: begin
        if (win_valid) begin
          grant_id_d         = win_id;
          m_waddr_d          = waddr_arr[win_id];
          m_wsize_d          = wsize_arr[win_id];
          ch_wbusy_d         = '0;
          ch_wbusy_d[win_id] = 1'b1;
          m_wareq_d          = 1'b1;
          rr_ptr_d           = win_id;
          clr_mask[win_id]   = 1'b1;
          to_cnt_d           = '0;
          state_d            = S_REQ;
        end
      end
      S_REQ: begin
        if (m_wbusy) begin
          m_wareq_d = 1'b0;
          state_d   = S_BUSY;
        end else if (to_hit) begin
          m_wareq_d  = 1'b0;
          ch_wbusy_d = '0;
          err_d      = 1'b1;
          state_d    = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      S_BUSY: begin
        if (!m_wbusy) begin
          ch_wbusy_d = '0;
          state_d    = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // An edge arriving in the grant cycle is ORed after the clear so it survives.
    pending_d = (pending_q & ~clr_mask) | rise;
  end

  // State and output registers; reset drops every request and output at once.
  always_ff @(posedge ui_clk or posedge ui_rst) begin
    if (ui_rst) begin
      state_q      <= S_IDLE;
      wareq_prev_q <= '0;
      pending_q    <= '0;
      rr_ptr_q     <= ID_W'(NCH - 1);
      grant_id_q   <= '0;
      m_waddr_q    <= '0;
      m_wsize_q    <= '0;
      ch_wbusy_q   <= '0;
      m_wareq_q    <= 1'b0;
      err_q        <= 1'b0;
      to_cnt_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q      <= state_d;
      wareq_prev_q <= ch_wareq;
      pending_q    <= pending_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      m_waddr_q    <= m_waddr_d;
      m_wsize_q    <= m_wsize_d;
      ch_wbusy_q   <= ch_wbusy_d;
      m_wareq_q    <= m_wareq_d;
      err_q        <= err_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  assign xfer_phase = (state_q == S_REQ) || (state_q == S_BUSY);

  // Data path steered by the registered grant; beat strobes only during a burst.
  always_comb begin
    m_wdata = wdata_arr[grant_id_q];
    for (int i = 0; i < NCH; i++) begin
      ch_wrd[i] = m_wrd && xfer_phase && (grant_id_q == ID_W'(i));
    end
  end

  assign ch_wbusy    = ch_wbusy_q;
  assign m_waddr     = m_waddr_q;
  assign m_wsize     = m_wsize_q;
  assign m_wareq     = m_wareq_q;
  assign grant_id    = grant_id_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_vsdma_wr_arbiter.sv
// Directed bench for vsdma_wr_arbiter: one round-robin instance (a_) and one
// fixed-priority instance (b_) share all inputs; each step checks the instance
// under test against hand-computed values.
module tb_vsdma_wr_arbiter;

  localparam int NCH    = 4;
  localparam int ADDR_W = 28;
  localparam int DATA_W = 256;
  localparam int SIZE_W = 16;
  localparam int ID_W   = $clog2(NCH);

  logic                  ui_clk = 1'b0;
  logic                  ui_rst;
  logic [NCH*ADDR_W-1:0] ch_waddr;
  logic [NCH-1:0]        ch_wareq;
  logic [NCH*SIZE_W-1:0] ch_wsize;
  logic [NCH*DATA_W-1:0] ch_wdata;
  logic                  m_wbusy;
  logic                  m_wrd;

  logic [NCH-1:0]    a_ch_wbusy, a_ch_wrd, b_ch_wbusy, b_ch_wrd;
  logic [ADDR_W-1:0] a_m_waddr, b_m_waddr;
  logic              a_m_wareq, b_m_wareq;
  logic [SIZE_W-1:0] a_m_wsize, b_m_wsize;
  logic [DATA_W-1:0] a_m_wdata, b_m_wdata;
  logic [ID_W-1:0]   a_grant_id, b_grant_id;
  logic              a_err_timeout, b_err_timeout;

  logic              sel_b;
  logic [NCH-1:0]    s_ch_wbusy, s_ch_wrd;
  logic [ADDR_W-1:0] s_m_waddr;
  logic              s_m_wareq;
  logic [SIZE_W-1:0] s_m_wsize;
  logic [DATA_W-1:0] s_m_wdata;
  logic [ID_W-1:0]   s_grant_id;
  logic              s_err_timeout;

  logic [ADDR_W-1:0] addr_tab [NCH];
  logic [SIZE_W-1:0] size_tab [NCH];

  int checks = 0;
  int errors = 0;

  vsdma_wr_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
                     .RR_MODE(1), .TIMEOUT(8)) u_rr (
    .ui_clk(ui_clk), .ui_rst(ui_rst),
    .ch_waddr(ch_waddr), .ch_wareq(ch_wareq), .ch_wsize(ch_wsize), .ch_wdata(ch_wdata),
    .ch_wbusy(a_ch_wbusy), .ch_wrd(a_ch_wrd),
    .m_waddr(a_m_waddr), .m_wareq(a_m_wareq), .m_wsize(a_m_wsize), .m_wbusy(m_wbusy),
    .m_wdata(a_m_wdata), .m_wrd(m_wrd), .grant_id(a_grant_id), .err_timeout(a_err_timeout)
  );

  vsdma_wr_arbiter #(.NCH(NCH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W),
                     .RR_MODE(0), .TIMEOUT(8)) u_fp (
    .ui_clk(ui_clk), .ui_rst(ui_rst),
    .ch_waddr(ch_waddr), .ch_wareq(ch_wareq), .ch_wsize(ch_wsize), .ch_wdata(ch_wdata),
    .ch_wbusy(b_ch_wbusy), .ch_wrd(b_ch_wrd),
    .m_waddr(b_m_waddr), .m_wareq(b_m_wareq), .m_wsize(b_m_wsize), .m_wbusy(m_wbusy),
    .m_wdata(b_m_wdata), .m_wrd(m_wrd), .grant_id(b_grant_id), .err_timeout(b_err_timeout)
  );

  assign s_ch_wbusy    = sel_b ? b_ch_wbusy    : a_ch_wbusy;
  assign s_ch_wrd      = sel_b ? b_ch_wrd      : a_ch_wrd;
  assign s_m_waddr     = sel_b ? b_m_waddr     : a_m_waddr;
  assign s_m_wareq     = sel_b ? b_m_wareq     : a_m_wareq;
  assign s_m_wsize     = sel_b ? b_m_wsize     : a_m_wsize;
  assign s_m_wdata     = sel_b ? b_m_wdata     : a_m_wdata;
  assign s_grant_id    = sel_b ? b_grant_id    : a_grant_id;
  assign s_err_timeout = sel_b ? b_err_timeout : a_err_timeout;

  always #5 ui_clk = ~ui_clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 3 time units after the rising edge.
  task automatic tick();
    @(posedge ui_clk);
    #3;
  endtask

  task automatic do_reset();
    ui_rst   = 1'b1;
    ch_wareq = '0;
    m_wbusy  = 1'b0;
    m_wrd    = 1'b0;
    tick();
    tick();
    ui_rst = 1'b0;
    tick();
  endtask

  // Wait for a grant, check it, run a short burst; rereq channels drop and re-raise their request mid-burst.
  task automatic serve(input int exp_id, input logic [NCH-1:0] rereq);
    int n;
    logic [NCH-1:0] oh;
    oh = '0;
    oh[exp_id] = 1'b1;
    n = 0;
    while (s_m_wareq !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("grant_wait", 256'(s_m_wareq), 256'(1));
    check("grant_id", 256'(s_grant_id), 256'(exp_id));
    check("grant_busy", 256'(s_ch_wbusy), 256'(oh));
    check("grant_addr", 256'(s_m_waddr), 256'(addr_tab[exp_id]));
    check("grant_size", 256'(s_m_wsize), 256'(size_tab[exp_id]));
    m_wbusy  = 1'b1;
    ch_wareq = ch_wareq & ~rereq;
    tick();
    check("busy_wareq_low", 256'(s_m_wareq), 256'(0));
    check("busy_hold", 256'(s_ch_wbusy), 256'(oh));
    ch_wareq = ch_wareq | rereq;
    tick();
    m_wbusy = 1'b0;
    tick();
    check("done_busy_clear", 256'(s_ch_wbusy), 256'(0));
    check("done_wareq", 256'(s_m_wareq), 256'(0));
  endtask

  initial begin
    logic [DATA_W-1:0] wtmp;

    addr_tab = '{28'h0A00000, 28'h0B00000, 28'h0010000, 28'h0D00000};
    size_tab = '{16'd4, 16'd8, 16'd16, 16'd32};
    for (int i = 0; i < NCH; i++) begin
      ch_waddr[i*ADDR_W +: ADDR_W] = addr_tab[i];
      ch_wsize[i*SIZE_W +: SIZE_W] = size_tab[i];
      ch_wdata[i*DATA_W +: DATA_W] = {8{32'hDA7A_0000 | 32'(i)}};
    end
    sel_b    = 1'b0;
    ui_rst   = 1'b1;
    ch_wareq = '0;
    m_wbusy  = 1'b0;
    m_wrd    = 1'b1;

    // Reset values (m_wrd held high to show ch_wrd stays low).
    tick();
    tick();
    #1;
    check("rst_wareq", 256'(a_m_wareq), 256'(0));
    check("rst_wbusy", 256'(a_ch_wbusy), 256'(0));
    check("rst_grant_id", 256'(a_grant_id), 256'(0));
    check("rst_addr", 256'(a_m_waddr), 256'(0));
    check("rst_size", 256'(a_m_wsize), 256'(0));
    check("rst_err", 256'(a_err_timeout), 256'(0));
    check("rst_wrd", 256'(a_ch_wrd), 256'(0));
    m_wrd  = 1'b0;
    ui_rst = 1'b0;
    tick();

    // 1: single request on ch2, two-cycle latency, held through a dropped level.
    ch_wareq = 4'b0100;
    tick();
    check("t1_lat1_wareq", 256'(a_m_wareq), 256'(0));
    tick();
    check("t1_lat2_wareq", 256'(a_m_wareq), 256'(1));
    check("t1_grant_id", 256'(a_grant_id), 256'(2));
    check("t1_wbusy", 256'(a_ch_wbusy), 256'(4'b0100));
    check("t1_addr", 256'(a_m_waddr), 256'(28'h0010000));
    check("t1_size", 256'(a_m_wsize), 256'(16));
    tick();
    ch_wareq = '0;
    check("t1_req_hold", 256'(a_m_wareq), 256'(1));
    tick();
    m_wbusy = 1'b1;
    tick();
    check("t1_busy_wareq", 256'(a_m_wareq), 256'(0));
    check("t1_busy_wbusy", 256'(a_ch_wbusy), 256'(4'b0100));
    tick();
    tick();
    m_wbusy = 1'b0;
    tick();
    check("t1_done_wbusy", 256'(a_ch_wbusy), 256'(0));
    check("t1_done_grant_id", 256'(a_grant_id), 256'(2));
    tick();
    check("t1_idle_wareq", 256'(a_m_wareq), 256'(0));

    // 2: simultaneous edges, round-robin order 0,1,2,3.
    do_reset();
    sel_b    = 1'b0;
    ch_wareq = 4'b1111;
    serve(0, 4'b0000);
    ch_wareq = '0;
    serve(1, 4'b0000);
    serve(2, 4'b0000);
    serve(3, 4'b0000);

    // 3: fixed priority, ch0 re-requests during its bursts and keeps winning.
    do_reset();
    sel_b    = 1'b1;
    ch_wareq = 4'b1111;
    serve(0, 4'b0001);
    serve(0, 4'b0001);
    serve(0, 4'b0000);
    serve(1, 4'b0000);
    serve(2, 4'b0000);
    serve(3, 4'b0000);
    ch_wareq = '0;

    // 4: no acknowledge, timeout after 8 REQ cycles, then next pending channel.
    do_reset();
    sel_b    = 1'b0;
    ch_wareq = 4'b1010;
    tick();
    check("t4_lat1_wareq", 256'(a_m_wareq), 256'(0));
    tick();
    check("t4_grant_id", 256'(a_grant_id), 256'(1));
    check("t4_wareq", 256'(a_m_wareq), 256'(1));
    repeat (7) tick();
    check("t4_pre_wareq", 256'(a_m_wareq), 256'(1));
    check("t4_pre_err", 256'(a_err_timeout), 256'(0));
    tick();
    check("t4_err_pulse", 256'(a_err_timeout), 256'(1));
    check("t4_err_wareq", 256'(a_m_wareq), 256'(0));
    check("t4_err_wbusy", 256'(a_ch_wbusy), 256'(0));
    tick();
    check("t4_err_end", 256'(a_err_timeout), 256'(0));
    check("t4_next_grant", 256'(a_grant_id), 256'(3));
    check("t4_next_wbusy", 256'(a_ch_wbusy), 256'(4'b1000));
    serve(3, 4'b0000);
    ch_wareq = '0;

    // 5: ch1 burst, beat strobes and data mux follow the granted channel.
    do_reset();
    sel_b = 1'b0;
    m_wrd = 1'b1;
    #1;
    check("t5_idle_wrd", 256'(a_ch_wrd), 256'(0));
    ch_wareq = 4'b0010;
    tick();
    tick();
    check("t5_grant_id", 256'(a_grant_id), 256'(1));
    m_wbusy = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      m_wrd = (i % 2 == 0);
      wtmp  = {8{32'hC0DE_0000 + 32'(i)}};
      ch_wdata[1*DATA_W +: DATA_W] = wtmp;
      #1;
      check("t5_wrd", 256'(a_ch_wrd), (i % 2 == 0) ? 256'(4'b0010) : 256'(0));
      check("t5_wdata", a_m_wdata, wtmp);
      tick();
    end
    m_wbusy = 1'b0;
    m_wrd   = 1'b1;
    tick();
    check("t5_done_wrd", 256'(a_ch_wrd), 256'(0));
    m_wrd    = 1'b0;
    ch_wareq = '0;
    tick();

    // 6: reset during BUSY with ch1/ch3 pending; pending is discarded.
    ch_wareq = 4'b0001;
    tick();
    tick();
    check("t6_grant_id", 256'(a_grant_id), 256'(0));
    m_wbusy = 1'b1;
    tick();
    ch_wareq = 4'b1011;
    tick();
    #2;
    ui_rst = 1'b1;
    m_wrd  = 1'b1;
    #1;
    check("t6_rst_wareq", 256'(a_m_wareq), 256'(0));
    check("t6_rst_wbusy", 256'(a_ch_wbusy), 256'(0));
    check("t6_rst_grant_id", 256'(a_grant_id), 256'(0));
    check("t6_rst_addr", 256'(a_m_waddr), 256'(0));
    check("t6_rst_size", 256'(a_m_wsize), 256'(0));
    check("t6_rst_wrd", 256'(a_ch_wrd), 256'(0));
    ch_wareq = '0;
    m_wbusy  = 1'b0;
    m_wrd    = 1'b0;
    tick();
    tick();
    ui_rst = 1'b0;
    tick();
    tick();
    check("t6_no_stale_req", 256'(a_m_wareq), 256'(0));
    check("t6_no_stale_busy", 256'(a_ch_wbusy), 256'(0));
    ch_wareq = 4'b0001;
    serve(0, 4'b0000);
    ch_wareq = '0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
